// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: idle/serve/play/pause/miss/over flow, lives, score,
// level and paddle speed for the VGA paddle/ball datapath.
module game_flow_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int SPEED_INIT     = 2,
  parameter int SPEED_MAX      = 6,
  parameter int HITS_PER_LEVEL = 5,
  parameter int SERVE_FRAMES   = 60,
  parameter int OVER_FRAMES    = 120
) (
  input  logic       clk_25M_reg,
  input  logic       rst_n,
  input  logic       vs,
  input  logic       start_btn,
  input  logic       lose,
  input  logic       get,
  output logic [3:0] move_speed,
  output logic       run,
  output logic       serve_pulse,
  output logic [1:0] lives,
  output logic [9:0] score,
  output logic [2:0] level,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_MISS  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] LIV_I   = 2'(LIVES_INIT);
  localparam logic [3:0] SPD_I   = 4'(SPEED_INIT);
  localparam logic [3:0] SPD_M   = 4'(SPEED_MAX);
  localparam logic [7:0] HITS_N  = 8'(HITS_PER_LEVEL);
  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] OVER_N  = 8'(OVER_FRAMES);

  state_t     state_q, state_d;
  logic       start_s1_q, start_s2_q, start_prev_q;
  logic       vs_prev_q, lose_prev_q, get_prev_q;
  logic [3:0] speed_q, speed_d;
  logic [7:0] hit_q, hit_d;
  logic [7:0] frame_q, frame_d;
  logic [1:0] lives_q, lives_d;
  logic [9:0] score_q, score_d;
  logic [2:0] level_q, level_d;
  logic [3:0] move_speed_q, move_speed_d;
  logic       run_q, run_d, serve_q, serve_d, over_q, over_d;

  logic start_rise, frame_tick, lose_rise, get_rise;

  // History flops reset high so levels already asserted at release are not edges.
  assign start_rise = start_s2_q & ~start_prev_q;
  assign frame_tick = vs_prev_q & ~vs;
  assign lose_rise  = lose & ~lose_prev_q;
  assign get_rise   = get & ~get_prev_q;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    hit_d   = hit_q;
    frame_d = frame_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    serve_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          lives_d = LIV_I;
          score_d = '0;
          level_d = '0;
          speed_d = SPD_I;
          hit_d   = '0;
          frame_d = '0;
          serve_d = 1'b1;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (frame_q + 8'd1 == SERVE_N) state_d = S_PLAY;
          else                           frame_d = frame_q + 8'd1;
        end
      end
      S_PLAY: begin
        if (lose_rise) begin
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          state_d = S_MISS;
        end else begin
          if (get_rise) begin
            if (score_q != 10'h3FF) score_d = score_q + 10'd1;
            if (hit_q + 8'd1 == HITS_N) begin
              hit_d = '0;
              if (speed_q < SPD_M) speed_d = speed_q + 4'd1;
              if (level_q != 3'd7) level_d = level_q + 3'd1;
            end else begin
              hit_d = hit_q + 8'd1;
            end
          end
          if (start_rise) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_rise) state_d = S_PLAY;
      end
      S_MISS: begin
        frame_d = '0;
        if (lives_q == 2'd0) begin
          state_d = S_OVER;
        end else begin
          serve_d = 1'b1;
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (frame_tick) begin
          if (frame_q + 8'd1 == OVER_N) state_d = S_IDLE;
          else                          frame_d = frame_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    move_speed_d = (state_d == S_PLAY) ? speed_d : 4'd0;
    run_d        = (state_d == S_PLAY);
    over_d       = (state_d == S_OVER);
  end

  always_ff @(posedge clk_25M_reg or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_s1_q   <= 1'b1;
      start_s2_q   <= 1'b1;
      start_prev_q <= 1'b1;
      vs_prev_q    <= 1'b1;
      lose_prev_q  <= 1'b1;
      get_prev_q   <= 1'b1;
      speed_q      <= SPD_I;
      hit_q        <= '0;
      frame_q      <= '0;
      lives_q      <= '0;
      score_q      <= '0;
      level_q      <= '0;
      move_speed_q <= '0;
      run_q        <= 1'b0;
      serve_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_s1_q   <= start_btn;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      vs_prev_q    <= vs;
      lose_prev_q  <= lose;
      get_prev_q   <= get;
      speed_q      <= speed_d;
      hit_q        <= hit_d;
      frame_q      <= frame_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      level_q      <= level_d;
      move_speed_q <= move_speed_d;
      run_q        <= run_d;
      serve_q      <= serve_d;
      over_q       <= over_d;
    end
  end

  assign move_speed  = move_speed_q;
  assign run         = run_q;
  assign serve_pulse = serve_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level       = level_q;
  assign game_over   = over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: expected snapshots are queued as
// stimulus is driven and popped when the DUT state is sampled.
module tb_game_flow_ctrl;
  logic       clk_25M_reg = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic       start_btn = 1'b0;
  logic       lose = 1'b0;
  logic       get = 1'b0;
  logic [3:0] move_speed;
  logic       run, serve_pulse, game_over;
  logic [1:0] lives;
  logic [9:0] score;
  logic [2:0] level, state;

  game_flow_ctrl dut (
    .clk_25M_reg(clk_25M_reg), .rst_n(rst_n), .vs(vs), .start_btn(start_btn),
    .lose(lose), .get(get), .move_speed(move_speed), .run(run),
    .serve_pulse(serve_pulse), .lives(lives), .score(score), .level(level),
    .game_over(game_over), .state(state)
  );

  always #20 clk_25M_reg = ~clk_25M_reg;

  typedef logic [23:0] snap_t;
  snap_t sb_q[$];
  snap_t exp_s;
  int n_tests = 0;
  int n_fail  = 0;
  int m_lives, m_score, m_level, m_speed, m_hit;

  // Expected {state, lives, score, level, move_speed, run, game_over}
  function automatic snap_t mk(input logic [2:0] st);
    return {st, 2'(m_lives), 10'(m_score), 3'(m_level),
            (st == 3'd2) ? 4'(m_speed) : 4'd0, st == 3'd2, st == 3'd5};
  endfunction

  function automatic snap_t obs();
    return {state, lives, score, level, move_speed, run, game_over};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25M_reg);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b0; tick(1);
      vs = 1'b1; tick(1);
    end
  endtask

  task automatic press_start(input int hold);
    start_btn = 1'b1; tick(hold);
    start_btn = 1'b0; tick(4);
  endtask

  task automatic model_new_game();
    m_lives = 3; m_score = 0; m_level = 0; m_speed = 2; m_hit = 0;
  endtask

  task automatic get_pulse(input bit upd);
    get = 1'b1; tick(1);
    get = 1'b0; tick(1);
    if (upd) begin
      if (m_score < 1023) m_score++;
      m_hit++;
      if (m_hit == 5) begin
        m_hit = 0;
        if (m_speed < 6) m_speed++;
        if (m_level < 7) m_level++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    m_lives = 0; m_score = 0; m_level = 0; m_speed = 2; m_hit = 0;
    sb_q.push_back(mk(3'd0));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL reset_state got %h exp %h", obs(), exp_s);
    end
    n_tests++;
    if (serve_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_serve got %b exp 0", serve_pulse);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_start();
    int entry, pulses;
    entry = -1; pulses = 0;
    start_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (serve_pulse === 1'b1) pulses++;
      if (entry < 0 && state === 3'd1) entry = k;
    end
    start_btn = 1'b0;
    n_tests++;
    if (entry < 3 || entry > 4) begin
      n_fail++; $display("FAIL start_latency got %0d exp 3..4", entry);
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL serve_pulse_count got %0d exp 1", pulses);
    end
    model_new_game();
    sb_q.push_back(mk(3'd1));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL start_serve got %h exp %h", obs(), exp_s);
    end
    tick(4);
    frames(59);
    sb_q.push_back(mk(3'd1));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL serve_59 got %h exp %h", obs(), exp_s);
    end
    frames(1);
    sb_q.push_back(mk(3'd2));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL serve_to_play got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_levels();
    for (int i = 1; i <= 30; i++) begin
      get_pulse(1'b1);
      sb_q.push_back(mk(3'd2));
      exp_s = sb_q.pop_front(); n_tests++;
      if (obs() !== exp_s) begin
        n_fail++; $display("FAIL hit_%0d got %h exp %h", i, obs(), exp_s);
      end
      if (i == 5) begin
        n_tests++;
        if (score !== 10'd5 || level !== 3'd1 || move_speed !== 4'd3) begin
          n_fail++;
          $display("FAIL level_up got score=%0d level=%0d speed=%0d exp 5/1/3", score, level, move_speed);
        end
      end
    end
    n_tests++;
    if (level !== 3'd6 || move_speed !== 4'd6) begin
      n_fail++; $display("FAIL speed_sat got level=%0d speed=%0d exp 6/6", level, move_speed);
    end
  endtask

  task automatic test_miss_over();
    for (int r = 0; r < 3; r++) begin
      lose = 1'b1; tick(1);
      m_lives--;
      sb_q.push_back(mk(3'd4));
      exp_s = sb_q.pop_front(); n_tests++;
      if (obs() !== exp_s) begin
        n_fail++; $display("FAIL miss_%0d got %h exp %h", r, obs(), exp_s);
      end
      lose = 1'b0; tick(1);
      if (m_lives > 0) begin
        sb_q.push_back(mk(3'd1));
        exp_s = sb_q.pop_front(); n_tests++;
        if (obs() !== exp_s || serve_pulse !== 1'b1) begin
          n_fail++; $display("FAIL miss_to_serve_%0d got %h/%b exp %h/1", r, obs(), serve_pulse, exp_s);
        end
        frames(60);
        sb_q.push_back(mk(3'd2));
        exp_s = sb_q.pop_front(); n_tests++;
        if (obs() !== exp_s) begin
          n_fail++; $display("FAIL reserve_play_%0d got %h exp %h", r, obs(), exp_s);
        end
      end else begin
        sb_q.push_back(mk(3'd5));
        exp_s = sb_q.pop_front(); n_tests++;
        if (obs() !== exp_s) begin
          n_fail++; $display("FAIL miss_to_over got %h exp %h", obs(), exp_s);
        end
      end
    end
    frames(119);
    sb_q.push_back(mk(3'd5));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL over_119 got %h exp %h", obs(), exp_s);
    end
    frames(1);
    sb_q.push_back(mk(3'd0));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s || score !== 10'd30) begin
      n_fail++; $display("FAIL over_to_idle got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_simultaneous();
    press_start(4);
    model_new_game();
    frames(60);
    sb_q.push_back(mk(3'd2));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL restart_play got %h exp %h", obs(), exp_s);
    end
    get = 1'b1; lose = 1'b1; tick(1);
    m_lives--;
    sb_q.push_back(mk(3'd4));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL lose_beats_get got %h exp %h", obs(), exp_s);
    end
    get = 1'b0; lose = 1'b0; tick(1);
    frames(60);
    sb_q.push_back(mk(3'd2));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL simul_replay got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_pause();
    press_start(4);
    sb_q.push_back(mk(3'd3));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL pause_enter got %h exp %h", obs(), exp_s);
    end
    get_pulse(1'b0);
    sb_q.push_back(mk(3'd3));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL pause_get got %h exp %h", obs(), exp_s);
    end
    press_start(4);
    sb_q.push_back(mk(3'd2));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s || move_speed !== 4'd2) begin
      n_fail++; $display("FAIL pause_resume got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) get_pulse(1'b1);
    sb_q.push_back(mk(3'd2));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s || score !== 10'd7) begin
      n_fail++; $display("FAIL pre_reset got %h exp %h", obs(), exp_s);
    end
    get = 1'b1;
    @(posedge clk_25M_reg);
    #5 rst_n = 1'b0;
    #1;
    m_lives = 0; m_score = 0; m_level = 0; m_speed = 2; m_hit = 0;
    sb_q.push_back(mk(3'd0));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s || serve_pulse !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %h/%b exp %h/0", obs(), serve_pulse, exp_s);
    end
    tick(1);
    rst_n = 1'b1;
    tick(4);
    sb_q.push_back(mk(3'd0));
    exp_s = sb_q.pop_front(); n_tests++;
    if (obs() !== exp_s) begin
      n_fail++; $display("FAIL get_held_release got %h exp %h", obs(), exp_s);
    end
    get = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_start();
    test_levels();
    test_miss_over();
    test_simultaneous();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Game-level sequencer for the VGA paddle/ball game. It sits above the display/physics datapath and consumes the datapath's per-frame `lose` and `get` flags. It drives the datapath's `bar_move_speed` input and the gating and serve signals. It also tracks lives, score and difficulty level, and runs the idle → serve → play → miss → game-over flow using frame ticks derived from `vs`.

Parameters:
- LIVES_INIT, 3: lives loaded at game start; range 1..3.
- SPEED_INIT, 2: move speed at game start, in pixels/frame.
- SPEED_MAX, 6: speed saturation ceiling; must be ≤ 15.
- HITS_PER_LEVEL, 5: paddle hits needed per level-up; range 1..255.
- SERVE_FRAMES, 60: frames held in SERVE before play; range 1..255.
- OVER_FRAMES, 120: frames held in OVER before IDLE; range 1..255.

Ports:
- clk_25M_reg, input, 1: pixel clock, 25 MHz; all logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- vs, input, 1: vertical sync from the datapath; active-low pulse once per frame.
- start_btn, input, 1: asynchronous push button; starts the game, and toggles pause during play.
- lose, input, 1: level flag from the datapath; ball has fallen past the paddle.
- get, input, 1: level flag from the datapath; ball has bounced on the paddle.
- move_speed, output, 4: drives `bar_move_speed`; 0 freezes ball and paddle.
- run, output, 1: high only in PLAY.
- serve_pulse, output, 1: one-cycle request to the datapath to re-centre the ball.
- lives, output, 2: remaining lives.
- score, output, 10: paddle-hit count; saturates at 1023.
- level, output, 3: difficulty level; saturates at 7.
- game_over, output, 1: high in OVER.
- state, output, 3: FSM state encoding, for debug and for on-screen display.

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state = IDLE (0); move_speed = 0; run = 0; serve_pulse = 0.
  - lives = 0; score = 0; level = 0; game_over = 0.
  - Internal speed register = SPEED_INIT; hit counter = 0; frame counter = 0.
  - Synchroniser and all edge-detect history flops reset to 1.
- start_btn passes through a 2-FF synchroniser. start_rise is a one-cycle pulse on a 0→1 transition of the synchronised value.
- frame_tick is a one-cycle pulse when vs goes from 1 (previous cycle) to 0 (current cycle), i.e. a registered falling-edge detect.
- lose_rise and get_rise are one-cycle pulses on 0→1 transitions, sampled directly because the inputs share clk_25M_reg. Because history flops reset to 1, a level already high at reset release produces no edge.
- State encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, OVER=5.
- move_speed = internal speed register in PLAY, 0 in every other state (registered output).
- IDLE:
  - score and level from the last game are held.
  - On start_rise: load lives=LIVES_INIT, score=0, level=0, speed=SPEED_INIT, hit counter=0; go to SERVE.
- SERVE:
  - serve_pulse is high for exactly the first cycle in the state.
  - The frame counter clears on entry and increments on each frame_tick.
  - When the count reaches SERVE_FRAMES, go to PLAY.
  - lose, get and start are ignored.
- PLAY:
  - get_rise: score+1 (saturating) and hit counter+1.
  - When the hit counter reaches HITS_PER_LEVEL, in that same cycle: hit counter=0, speed=min(speed+1, SPEED_MAX), level+1 (saturating at 7).
  - lose_rise: lives−1, go to MISS.
  - lose_rise and get_rise in the same cycle: the lose path wins and score is unchanged.
  - start_rise with no lose_rise: go to PAUSE.
  - start_rise together with lose_rise: MISS wins.
- PAUSE:
  - run=0, move_speed=0.
  - lose and get are ignored.
  - start_rise returns to PLAY; speed, score and hit counter are unchanged.
- MISS:
  - Lasts exactly one cycle.
  - lives==0 goes to OVER; otherwise goes to SERVE, keeping the current speed and level.
- OVER:
  - game_over=1.
  - The frame counter clears on entry; when it reaches OVER_FRAMES, go to IDLE.
  - start is ignored until the state is left.
- lives never underflows: it is decremented only in PLAY, and only when it is ≥ 1.
- rst_n asserted mid-game aborts immediately to the reset values. There is no residual serve_pulse.
- Undefined state codes (6, 7) recover to IDLE on the next clock.

Test Plan:
- Reset, then start_btn held high for 10 cycles → after 3–4 cycles state=SERVE with a single serve_pulse cycle and lives=3. After 60 vs falling edges, state=PLAY, run=1, move_speed=2.
- In PLAY, 5 separate get pulses (each 0→1→0) → score=5, level=1, move_speed=3. A further 25 pulses → move_speed saturates at 6, level=6.
- In PLAY, a lose pulse → lives=2, state passes through MISS for exactly 1 cycle into SERVE, and move_speed=0 during SERVE. Repeat twice more → lives=0, state=OVER, game_over=1. After 120 frames, state=IDLE with score retained.
- get and lose rising in the same cycle in PLAY → score unchanged, lives decremented, state=MISS.
- start pulse in PLAY → PAUSE with move_speed=0. A get pulse during PAUSE leaves score unchanged. A second start pulse → PLAY with the prior speed.
- rst_n pulsed low for 1 cycle mid-PLAY with score=7 → all outputs take their reset values asynchronously. With get held high across the reset release, no score increment occurs.
